// File: rtl/branch_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : branch_ctrl_pkg                                                 |
// | Purpose  : Shared constants for the branch decision stage: branch codes,   |
// |            flag bit positions inside {C,Z,S,V} and the link register index.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package branch_ctrl_pkg;

  // Decoded branch codes; 13..15 are unassigned and reported as illegal.
  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_B    = 4'd1,
    BR_BR   = 4'd2,
    BR_BL   = 4'd3,
    BR_BLTZ = 4'd4,
    BR_BZ   = 4'd5,
    BR_BNZ  = 4'd6,
    BR_BCY  = 4'd7,
    BR_BNCY = 4'd8,
    BR_BS   = 4'd9,
    BR_BNS  = 4'd10,
    BR_BV   = 4'd11,
    BR_BNV  = 4'd12
  } br_code_e;

  // Bit positions of the architectural flags within the 4-bit flag vector.
  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_S = 1;
  localparam int FLG_V = 0;

  localparam int LINK_REG_DEF = 31;

endpackage : branch_ctrl_pkg
`default_nettype wire

// File: rtl/branch_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : branch_ctrl_if                                                  |
// | Purpose  : Bundle of the decode-side inputs and PC-stage outputs of the    |
// |            branch decision stage.                                          |
// |            master : drives pc/br_type/rs_val/alu flags/flag_we/cnt_clr     |
// |            slave  : drives branch/reg_en/register/link_*/flags/illegal_br/ |
// |                     taken_cnt                                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface branch_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic [31:0]      pc;
  logic [3:0]       br_type;
  logic [31:0]      rs_val;
  logic             alu_c;
  logic             alu_z;
  logic             alu_s;
  logic             alu_v;
  logic             flag_we;
  logic             cnt_clr;

  logic             branch;
  logic             reg_en;
  logic [31:0]      register;
  logic             link_we;
  logic [31:0]      link_addr;
  logic [4:0]       link_idx;
  logic [3:0]       flags;
  logic             illegal_br;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output pc, br_type, rs_val, alu_c, alu_z, alu_s, alu_v, flag_we, cnt_clr,
    input  branch, reg_en, register, link_we, link_addr, link_idx, flags,
           illegal_br, taken_cnt
  );

  modport slave (
    input  pc, br_type, rs_val, alu_c, alu_z, alu_s, alu_v, flag_we, cnt_clr,
    output branch, reg_en, register, link_we, link_addr, link_idx, flags,
           illegal_br, taken_cnt
  );
endinterface : branch_ctrl_if
`default_nettype wire

// File: rtl/branch_ctrl_br_cond_eval.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : br_cond_eval                                                    |
// | Purpose  : Purely combinational branch condition evaluation.               |
// |   br_type in 4   decoded branch code                                       |
// |   flags   in 4   registered {C,Z,S,V}                                      |
// |   rs_val  in 32  rs operand for zero/sign tests                            |
// |   taken   out 1  branch is taken                                           |
// |   reg_en  out 1  target comes from rs (BR only)                            |
// |   link_we out 1  call link write (BL only)                                 |
// |   illegal out 1  unassigned branch code                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module br_cond_eval
  import branch_ctrl_pkg::*;
(
  input  wire logic [3:0]  br_type,
  input  wire logic [3:0]  flags,
  input  wire logic [31:0] rs_val,
  output logic             taken,
  output logic             reg_en,
  output logic             link_we,
  output logic             illegal
);

  // No branch code tests Z; it is carried for completeness of the flag vector.
  logic w_unused_z;
  assign w_unused_z = flags[FLG_Z];

  logic w_rs_zero;
  assign w_rs_zero = (rs_val == 32'd0);

  always_comb begin
    taken   = 1'b0;
    reg_en  = 1'b0;
    link_we = 1'b0;
    illegal = 1'b0;
    case (br_code_e'(br_type))
      BR_NONE: ;
      BR_B:    taken = 1'b1;
      BR_BR: begin
        taken  = 1'b1;
        reg_en = 1'b1;
      end
      BR_BL: begin
        taken   = 1'b1;
        link_we = 1'b1;
      end
      BR_BLTZ: taken = rs_val[31];
      BR_BZ:   taken = w_rs_zero;
      BR_BNZ:  taken = ~w_rs_zero;
      BR_BCY:  taken = flags[FLG_C];
      BR_BNCY: taken = ~flags[FLG_C];
      BR_BS:   taken = flags[FLG_S];
      BR_BNS:  taken = ~flags[FLG_S];
      BR_BV:   taken = flags[FLG_V];
      BR_BNV:  taken = ~flags[FLG_V];
      default: illegal = 1'b1;
    endcase
  end

endmodule : br_cond_eval
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : branch_ctrl                                                     |
// | Purpose  : Branch decision stage feeding the PC update register. Holds the |
// |            {C,Z,S,V} flag register, decides branches with zero latency    |
// |            against the registered flags or rs, produces the call link     |
// |            write (pc+4 -> r[LINK_REG]) and a saturating taken counter.    |
// |   clk  in  system clock                                                    |
// |   rst  in  asynchronous active-high reset                                  |
// |   bus  slave modport of branch_ctrl_if (all data inputs and outputs)      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int LINK_REG = LINK_REG_DEF
) (
  input  wire logic     clk,
  input  wire logic     rst,
  branch_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_cnt;

  logic w_taken;
  logic w_reg_en;
  logic w_link_we;
  logic w_illegal;

  // Decision uses the registered flags, so a same-cycle flag write only
  // affects the next instruction.
  br_cond_eval u_cond (
    .br_type (bus.br_type),
    .flags   (r_flags),
    .rs_val  (bus.rs_val),
    .taken   (w_taken),
    .reg_en  (w_reg_en),
    .link_we (w_link_we),
    .illegal (w_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= 4'b0000;
      r_cnt   <= '0;
    end else begin
      if (bus.flag_we) begin
        r_flags <= {bus.alu_c, bus.alu_z, bus.alu_s, bus.alu_v};
      end
      // Clear wins over increment; the counter sticks at all-ones.
      if (bus.cnt_clr) begin
        r_cnt <= '0;
      end else if (w_taken && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end
    end
  end

  assign bus.branch     = w_taken;
  assign bus.reg_en     = w_reg_en;
  assign bus.register   = bus.rs_val;
  assign bus.link_we    = w_link_we;
  assign bus.link_addr  = bus.pc + 32'd4;
  assign bus.link_idx   = 5'(LINK_REG);
  assign bus.flags      = r_flags;
  assign bus.illegal_br = w_illegal;
  assign bus.taken_cnt  = r_cnt;

endmodule : branch_ctrl
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_branch_ctrl                                                  |
// | Purpose  : Self-checking bench for branch_ctrl (CNT_W=3) against a         |
// |            behavioural model of the branch rules, flags and counter.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_branch_ctrl;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  branch_ctrl_if #(.CNT_W(CNT_W)) bus ();

  branch_ctrl #(.CNT_W(CNT_W), .LINK_REG(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec;
  int         n_err;
  logic [3:0] m_flags;   // model flag register {C,Z,S,V}
  int         m_cnt;     // model taken counter

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Branch rule table written straight from the code list.
  function automatic logic model_taken(input int code, input logic [3:0] f, input logic [31:0] rs);
    logic c, s, v;
    c = f[3];
    s = f[1];
    v = f[0];
    case (code)
      1, 2, 3: return 1'b1;
      4:       return $signed(rs) < 0;
      5:       return rs == 32'd0;
      6:       return rs != 32'd0;
      7:       return c;
      8:       return !c;
      9:       return s;
      10:      return !s;
      11:      return v;
      12:      return !v;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one instruction at a negedge, check outputs mid-cycle, clock it,
  // then advance the model. Returns at the following negedge.
  task automatic apply(input int bt, input logic [31:0] rs, input logic [31:0] p,
                       input logic fwe, input logic [3:0] alu, input logic clr);
    logic        exp_tk;
    logic [31:0] exp_link;
    bus.br_type = 4'(bt);
    bus.rs_val  = rs;
    bus.pc      = p;
    bus.flag_we = fwe;
    {bus.alu_c, bus.alu_z, bus.alu_s, bus.alu_v} = alu;
    bus.cnt_clr = clr;
    #2;
    exp_tk   = model_taken(bt, m_flags, rs);
    exp_link = p + 32'd4;
    check("branch",     64'(bus.branch),     64'(exp_tk));
    check("reg_en",     64'(bus.reg_en),     64'(bt == 2));
    check("register",   64'(bus.register),   64'(rs));
    check("link_we",    64'(bus.link_we),    64'(bt == 3));
    check("link_addr",  64'(bus.link_addr),  64'(exp_link));
    check("link_idx",   64'(bus.link_idx),   64'd31);
    check("illegal_br", 64'(bus.illegal_br), 64'(bt >= 13));
    check("flags",      64'(bus.flags),      64'(m_flags));
    check("taken_cnt",  64'(bus.taken_cnt),  64'(m_cnt));
    @(posedge clk);
    if (clr)                         m_cnt = 0;
    else if (exp_tk && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    if (fwe) m_flags = alu;
    @(negedge clk);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    m_flags = 4'b0000;
    m_cnt   = 0;
    rst     = 1'b1;
    bus.pc = '0; bus.br_type = '0; bus.rs_val = '0;
    bus.alu_c = 0; bus.alu_z = 0; bus.alu_s = 0; bus.alu_v = 0;
    bus.flag_we = 0; bus.cnt_clr = 0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_flags",  64'(bus.flags),     64'd0);
    check("rst_cnt",    64'(bus.taken_cnt), 64'd0);
    check("rst_branch", 64'(bus.branch),    64'd0);
    check("rst_reg_en", 64'(bus.reg_en),    64'd0);
    check("rst_linkwe", 64'(bus.link_we),   64'd0);
    rst = 1'b0;
    apply(0, 32'h0, 32'h0, 0, 4'h0, 0);

    // Carry flag: set, test taken/not-taken, then write-and-test same cycle
    apply(0, 32'h0, 32'h10, 1, 4'b1000, 0);
    apply(7, 32'h0, 32'h14, 0, 4'h0, 0);
    apply(8, 32'h0, 32'h18, 0, 4'h0, 0);
    apply(0, 32'h0, 32'h1C, 1, 4'b0000, 0);
    apply(7, 32'h0, 32'h20, 1, 4'b1000, 0);   // old flags: not taken
    apply(7, 32'h0, 32'h24, 0, 4'h0, 0);      // new flags: taken

    // Register branch and call link
    apply(2, 32'h0000_0100, 32'h30, 0, 4'h0, 0);
    apply(3, 32'h0, 32'h40, 0, 4'h0, 0);
    apply(3, 32'h0, 32'hFFFF_FFFC, 0, 4'h0, 0);

    // rs sign / zero tests
    apply(4, 32'h8000_0000, 32'h50, 0, 4'h0, 0);
    apply(5, 32'h8000_0000, 32'h54, 0, 4'h0, 0);
    apply(6, 32'h8000_0000, 32'h58, 0, 4'h0, 0);
    apply(5, 32'h0, 32'h5C, 0, 4'h0, 0);
    apply(4, 32'h0, 32'h60, 0, 4'h0, 0);

    // Saturation, then clear racing a taken branch
    apply(0, 32'h0, 32'h0, 0, 4'h0, 1);
    for (int i = 0; i < 9; i++) apply(1, 32'h0, 32'h70, 0, 4'h0, 0);
    check("sat_cnt", 64'(bus.taken_cnt), 64'd7);
    apply(1, 32'h0, 32'h74, 0, 4'h0, 1);
    check("clr_cnt", 64'(bus.taken_cnt), 64'd0);

    // Illegal codes leave the counter alone
    apply(1, 32'h0, 32'h78, 0, 4'h0, 0);
    for (int i = 13; i <= 15; i++) apply(i, 32'h0, 32'h7C, 0, 4'h0, 0);
    check("illegal_cnt", 64'(bus.taken_cnt), 64'd1);

    // Asynchronous reset with all flags set
    apply(0, 32'h0, 32'h80, 1, 4'b1111, 0);
    check("flags_set", 64'(bus.flags), 64'hF);
    #2 rst = 1'b1;
    #1;
    check("async_flags", 64'(bus.flags),     64'd0);
    check("async_cnt",   64'(bus.taken_cnt), 64'd0);
    m_flags = 4'b0000;
    m_cnt   = 0;
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rs;
      logic [31:0] p;
      case ($urandom_range(0, 3))
        0:       rs = 32'h0;
        1:       rs = 32'h8000_0000 | $urandom;
        default: rs = $urandom;
      endcase
      p = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      apply($urandom_range(0, 15), rs, p, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_branch_ctrl
`default_nettype wire
